alg_autocor_ctrl: RTL and testbench

ALG_AUTOCOR_CTRL -- requirements
Module: alg_autocor_ctrl

---
 rtl/alg_autocor_ctrl_pkg.sv | 18 +
 rtl/alg_autocor.sv | 15 +
 rtl/alg_autocor_ctrl.sv | 117 +++++++++++
 tb/tb_alg_autocor_ctrl.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/alg_autocor_ctrl_pkg.sv
// Shared definitions for the autocorrelation DCO control loop.
// State encoding and bundle widths used by the controller and its sub-module.
package alg_autocor_ctrl_pkg;

    localparam int INC_W       = 8;
    localparam int NRISE_W     = 4;
    localparam int WIN_W       = 8;
    localparam int TARGET_RISE = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_COUNT  = 3'd1,
        ST_EVAL   = 3'd2,
        ST_UPDATE = 3'd3,
        ST_HOLD   = 3'd4
    } state_e;

endpackage

// File: rtl/alg_autocor.sv
// Maps a window edge count to a signed control increment.
// Error against the target edge count, scaled by a fixed loop gain of 8.
module alg_autocor
    import alg_autocor_ctrl_pkg::*;
(
    input  logic [NRISE_W-1:0] nrise_i,
    output logic [INC_W-1:0]   inc_o
);

    logic [INC_W-1:0] err;

    assign err   = INC_W'(TARGET_RISE) - {{(INC_W-NRISE_W){1'b0}}, nrise_i};
    assign inc_o = err << 3;

endmodule

// File: rtl/alg_autocor_ctrl.sv
// Windowed edge counter driving a saturating DCO control-word accumulator
// with a valid/ready hand-off of each update.
module alg_autocor_ctrl
    import alg_autocor_ctrl_pkg::*;
#(
    parameter int WIN_LEN = 16,
    parameter int ACC_W   = 12
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    sig_in,
    output logic signed [ACC_W-1:0] ctrl_word,
    output logic                    ctrl_valid,
    input  logic                    ctrl_ready,
    output logic                    busy,
    output logic [NRISE_W-1:0]      nrise_dbg
);

    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WIN_LEN - 1);

    state_e             state_q;
    logic [2:0]         sync_q;
    logic [WIN_W-1:0]   win_q;
    logic [NRISE_W-1:0] edge_q;
    logic [NRISE_W-1:0] edge_d;
    logic [NRISE_W-1:0] nrise_q;
    logic [INC_W-1:0]   inc_q;
    logic [INC_W-1:0]   inc;
    logic [ACC_W-1:0]   acc_q;
    logic [ACC_W-1:0]   acc_d;
    logic [ACC_W:0]     sum;
    logic               valid_q;
    logic               rise;

    alg_autocor u_autocor (
        .nrise_i (nrise_q),
        .inc_o   (inc)
    );

    assign rise   = sync_q[1] & ~sync_q[2];
    assign edge_d = (rise && edge_q != '1) ? edge_q + NRISE_W'(1) : edge_q;

    // One guard bit exposes overflow; clamp instead of wrapping.
    assign sum = {acc_q[ACC_W-1], acc_q}
               + {{(ACC_W+1-INC_W){inc_q[INC_W-1]}}, inc_q};

    always_comb begin
        acc_d = sum[ACC_W-1:0];
        if (sum[ACC_W] != sum[ACC_W-1]) begin
            acc_d = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                               : {1'b0, {(ACC_W-1){1'b1}}};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sync_q  <= '0;
            win_q   <= '0;
            edge_q  <= '0;
            nrise_q <= '0;
            inc_q   <= '0;
            acc_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[1:0], sig_in};
            unique case (state_q)
                ST_IDLE: begin
                    if (en) begin
                        state_q <= ST_COUNT;
                        win_q   <= '0;
                        edge_q  <= '0;
                    end
                end
                ST_COUNT: begin
                    if (!en) begin
                        state_q <= ST_IDLE;
                        edge_q  <= '0;
                    end else begin
                        edge_q <= edge_d;
                        if (win_q == WIN_LAST) begin
                            state_q <= ST_EVAL;
                            nrise_q <= edge_d;
                        end else begin
                            win_q <= win_q + WIN_W'(1);
                        end
                    end
                end
                ST_EVAL: begin
                    inc_q   <= inc;
                    state_q <= ST_UPDATE;
                end
                ST_UPDATE: begin
                    acc_q   <= acc_d;
                    valid_q <= 1'b1;
                    state_q <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (ctrl_ready) begin
                        valid_q <= 1'b0;
                        win_q   <= '0;
                        edge_q  <= '0;
                        state_q <= en ? ST_COUNT : ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign ctrl_word  = acc_q;
    assign ctrl_valid = valid_q;
    assign busy       = (state_q != ST_IDLE);
    assign nrise_dbg  = nrise_q;

endmodule

// File: tb/tb_alg_autocor_ctrl.sv
// Directed checks of window counting, saturation, hand-off and reset.
// Long window so that 20 synchronized edges fit inside one window.
module tb_alg_autocor_ctrl;

    localparam int WIN = 48;
    localparam int AW  = 9;
    localparam int LAT = WIN + 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic          sig_in = 1'b0;
    logic          ctrl_ready = 1'b1;
    logic [AW-1:0] ctrl_word;
    logic          ctrl_valid;
    logic          busy;
    logic [3:0]    nrise_dbg;

    int n_chk  = 0;
    int n_fail = 0;
    int lat;
    int exp_w;
    bit seen;

    alg_autocor_ctrl #(.WIN_LEN(WIN), .ACC_W(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .sig_in     (sig_in),
        .ctrl_word  (ctrl_word),
        .ctrl_valid (ctrl_valid),
        .ctrl_ready (ctrl_ready),
        .busy       (busy),
        .nrise_dbg  (nrise_dbg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] pulses(input int n);
        logic [63:0] m = '0;
        for (int i = 0; i < n; i++) m[2*i] = 1'b1;
        return m;
    endfunction

    // Starts at a negedge; sig_in follows pat one bit per cycle.
    task automatic run_win(input logic [63:0] pat, output int l);
        l  = 0;
        en = 1'b1;
        for (int k = 1; k <= 70; k++) begin
            @(negedge clk);
            if (ctrl_valid) begin
                l = k;
                break;
            end
            sig_in = (k <= 64) ? pat[k-1] : 1'b0;
        end
        sig_in = 1'b0;
        if (l == 0) chk("win_timeout", 0, 1);
    endtask

    task automatic end_win();
        en = 1'b0;
        @(negedge clk);
        chk("valid_drop", int'(ctrl_valid), 0);
        chk("idle_busy", int'(busy), 0);
    endtask

    function automatic int sat(input int v);
        if (v > 255) return 255;
        if (v < -256) return -256;
        return v;
    endfunction

    initial begin
        #12;
        chk("rst_word", int'($signed(ctrl_word)), 0);
        chk("rst_valid", int'(ctrl_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_nrise", int'(nrise_dbg), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_win(pulses(3), lat);
        chk("lat3", lat, LAT);
        chk("nrise3", int'(nrise_dbg), 3);
        chk("word3", int'($signed(ctrl_word)), 40);
        chk("busy_hold", int'(busy), 1);
        end_win();

        run_win(pulses(20), lat);
        chk("nrise20", int'(nrise_dbg), 15);
        chk("word20", int'($signed(ctrl_word)), -16);
        end_win();

        run_win(64'h1 << 45, lat);
        chk("nrise_last", int'(nrise_dbg), 1);
        chk("word_last", int'($signed(ctrl_word)), 40);
        end_win();

        run_win(64'h1 << 46, lat);
        chk("nrise_after", int'(nrise_dbg), 0);
        chk("word_after", int'($signed(ctrl_word)), 104);
        end_win();

        exp_w = 104;
        for (int w = 0; w < 20; w++) begin
            run_win(pulses(7), lat);
            exp_w = sat(exp_w + 8);
            chk("sat_pos", int'($signed(ctrl_word)), exp_w);
            end_win();
        end
        chk("clamp_pos", int'($signed(ctrl_word)), 255);

        for (int w = 0; w < 11; w++) begin
            run_win(pulses(16), lat);
            exp_w = sat(exp_w - 56);
            chk("sat_neg", int'($signed(ctrl_word)), exp_w);
            chk("nrise16", int'(nrise_dbg), 15);
            end_win();
        end
        chk("clamp_neg", int'($signed(ctrl_word)), -256);

        ctrl_ready = 1'b0;
        run_win(pulses(3), lat);
        for (int j = 1; j <= 10; j++) begin
            @(negedge clk);
            sig_in = (j <= 7) && (j % 2 == 1);
        end
        sig_in = 1'b0;
        chk("hold_valid", int'(ctrl_valid), 1);
        chk("hold_word", int'($signed(ctrl_word)), -216);
        chk("hold_nrise", int'(nrise_dbg), 3);
        ctrl_ready = 1'b1;
        run_win(pulses(2), lat);
        chk("lat_after_hold", lat, LAT);
        chk("nrise_new", int'(nrise_dbg), 2);
        chk("word_new", int'($signed(ctrl_word)), -168);
        end_win();

        en   = 1'b1;
        seen = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            sig_in = (k <= 5) && (k % 2 == 1);
        end
        en     = 1'b0;
        sig_in = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (ctrl_valid) seen = 1'b1;
        end
        chk("abort_valid", int'(seen), 0);
        chk("abort_word", int'($signed(ctrl_word)), -168);
        chk("abort_nrise", int'(nrise_dbg), 2);
        chk("abort_busy", int'(busy), 0);
        run_win(pulses(1), lat);
        chk("lat_reen", lat, LAT);
        chk("nrise_reen", int'(nrise_dbg), 1);
        chk("word_reen", int'($signed(ctrl_word)), -112);
        end_win();

        ctrl_ready = 1'b0;
        run_win(pulses(3), lat);
        chk("pre_rst_word", int'($signed(ctrl_word)), -72);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_word", int'($signed(ctrl_word)), 0);
        chk("arst_valid", int'(ctrl_valid), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_nrise", int'(nrise_dbg), 0);
        @(negedge clk);
        rst_n      = 1'b1;
        ctrl_ready = 1'b1;
        run_win('0, lat);
        chk("lat_post_rst", lat, LAT);
        chk("nrise_post_rst", int'(nrise_dbg), 0);
        chk("word_post_rst", int'($signed(ctrl_word)), 64);
        end_win();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
